// File: rtl/linea_recog_pkg.sv
// ---------------------------------------------------------------------------
// linea_recog_pkg : shared FSM state type and default pattern parameters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package linea_recog_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int         DEF_PLEN    = 5;
  localparam logic [4:0] DEF_PATTERN = 5'b10011;
  localparam int         DEF_CW      = 8;

endpackage

`default_nettype wire

// File: rtl/linea_recog_if.sv
// ---------------------------------------------------------------------------
// linea_recog_if : serial lines, controls and match outputs of linea_recog
// conteggio exists only when LINEA_RECOG_COUNT_EN is defined. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface linea_recog_if
  import linea_recog_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CW       = DEF_CW
) ();

  logic [CHANNELS-1:0]    linea;
  logic [CHANNELS-1:0]    abilita;
  logic                   sovrapp;
  logic                   azzera;
  logic [CHANNELS-1:0]    u;
  logic                   any_u;
`ifdef LINEA_RECOG_COUNT_EN
  logic [CHANNELS*CW-1:0] conteggio;
`endif

  modport master (
    output linea, abilita, sovrapp, azzera,
`ifdef LINEA_RECOG_COUNT_EN
    input  conteggio,
`endif
    input  u, any_u
  );

  modport slave (
    input  linea, abilita, sovrapp, azzera,
`ifdef LINEA_RECOG_COUNT_EN
    output conteggio,
`endif
    output u, any_u
  );

endinterface

`default_nettype wire

// File: rtl/linea_recog_chan.sv
// ---------------------------------------------------------------------------
// linea_recog_chan : one serial line recogniser (FSM, history, match counter)
// Counter present only with LINEA_RECOG_COUNT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module linea_recog_chan
  import linea_recog_pkg::*;
#(
  parameter int             PLEN    = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN
`ifdef LINEA_RECOG_COUNT_EN
  , parameter int           CW      = DEF_CW
`endif
) (
  input  wire logic          clock,
  input  wire logic          reset,
  input  wire logic          linea,
  input  wire logic          abilita,
  input  wire logic          sovrapp,
`ifdef LINEA_RECOG_COUNT_EN
  input  wire logic          azzera,
  output logic [CW-1:0]      conteggio,
`endif
  output logic               u,
  output logic               u_next
);

  localparam int              CNTW     = $clog2(PLEN + 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(PLEN);

  state_t            state_q, state_d;
  logic [PLEN-1:0]   hist_q, hist_d, hist_shift;
  logic [CNTW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              u_q, u_d;
  logic              match;

  always_comb begin
    hist_shift = {hist_q[PLEN-2:0], linea};
    // In RUN the window is already full, so the fill count stays pinned.
    cnt_inc    = (state_q == ST_RUN) ? CNT_FULL : cnt_q + 1'b1;
    match      = (state_q != ST_INIT) && abilita &&
                 (cnt_inc == CNT_FULL) && (hist_shift == PATTERN);

    state_d = state_q;
    hist_d  = hist_q;
    cnt_d   = cnt_q;
    u_d     = match;

    if (!abilita) begin
      state_d = ST_INIT;
      hist_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          state_d = ST_FILL;
          hist_d  = '0;
          cnt_d   = '0;
        end
        ST_FILL, ST_RUN: begin
          hist_d  = hist_shift;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == CNT_FULL) ? ST_RUN : ST_FILL;
          // Non-overlapping mode demands a completely fresh window.
          if (match && !sovrapp) begin
            cnt_d   = '0;
            state_d = ST_FILL;
          end
        end
        default: begin
          state_d = ST_INIT;
          hist_d  = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      hist_q  <= '0;
      cnt_q   <= '0;
      u_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      u_q     <= u_d;
    end
  end

  assign u      = u_q;
  assign u_next = u_d;

`ifdef LINEA_RECOG_COUNT_EN
  logic [CW-1:0] count_q, count_d;

  // Clear wins over increment, but a coincident match is still counted.
  always_comb begin
    count_d = count_q;
    if (azzera)
      count_d = match ? CW'(1) : '0;
    else if (match && (count_q != {CW{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign conteggio = count_q;
`endif

endmodule

`default_nettype wire

// File: rtl/linea_recog.sv
// ---------------------------------------------------------------------------
// linea_recog : multi-channel serial pattern recogniser with any_u summary
// Optional match counters enabled by LINEA_RECOG_COUNT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module linea_recog
  import linea_recog_pkg::*;
#(
  parameter int              CHANNELS = 4,
  parameter int              PLEN     = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN  = DEF_PATTERN,
  parameter int              CW       = DEF_CW
) (
  input  wire logic     clock,
  input  wire logic     reset,
  linea_recog_if.slave  bus
);

  logic [CHANNELS-1:0] u_next;
  logic                any_u_q, any_u_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    linea_recog_chan #(
      .PLEN    (PLEN),
      .PATTERN (PATTERN)
`ifdef LINEA_RECOG_COUNT_EN
      , .CW    (CW)
`endif
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .linea     (bus.linea[i]),
      .abilita   (bus.abilita[i]),
      .sovrapp   (bus.sovrapp),
`ifdef LINEA_RECOG_COUNT_EN
      .azzera    (bus.azzera),
      .conteggio (bus.conteggio[i*CW +: CW]),
`endif
      .u         (bus.u[i]),
      .u_next    (u_next[i])
    );
  end

  // Built from the channels' next-state pulses so any_u lines up with u.
  always_comb begin
    any_u_d = |u_next;
  end

  always_ff @(posedge clock) begin
    if (reset)
      any_u_q <= 1'b0;
    else
      any_u_q <= any_u_d;
  end

  assign bus.any_u = any_u_q;

endmodule

`default_nettype wire

// File: tb/tb_linea_recog.sv
// ---------------------------------------------------------------------------
// tb_linea_recog : directed self-checking bench for linea_recog
// Counter checks active only with LINEA_RECOG_COUNT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_linea_recog;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  linea_recog_if #(.CHANNELS(4), .CW(8)) bus_a ();
  linea_recog_if #(.CHANNELS(2), .CW(2)) bus_b ();

  linea_recog #(
    .CHANNELS (4),
    .PLEN     (5),
    .PATTERN  (5'b10011),
    .CW       (8)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  linea_recog #(
    .CHANNELS (2),
    .PLEN     (5),
    .PATTERN  (5'b10101),
    .CW       (2)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step_a(input logic [3:0] ab, input logic [3:0] lin,
                        input logic [3:0] exp_u, input string tag);
    bus_a.abilita = ab;
    bus_a.linea   = lin;
    tick();
    check({tag, "_u"}, {28'd0, bus_a.u}, {28'd0, exp_u});
    check({tag, "_any"}, {31'd0, bus_a.any_u}, {31'd0, |exp_u});
  endtask

  task automatic stream_a(input logic [4:0] bits, input logic [4:0] exp, input string tag);
    for (int i = 4; i >= 0; i--)
      step_a(4'b0001, {3'b000, bits[i]}, {3'b000, exp[i]}, tag);
  endtask

  task automatic step_b(input logic [1:0] ab, input logic [1:0] lin, input logic azz,
                        input logic [1:0] exp_u, input string tag);
    bus_b.abilita = ab;
    bus_b.linea   = lin;
    bus_b.azzera  = azz;
    tick();
    check({tag, "_u"}, {30'd0, bus_b.u}, {30'd0, exp_u});
    check({tag, "_any"}, {31'd0, bus_b.any_u}, {31'd0, |exp_u});
  endtask

  task automatic stream_b(input logic [6:0] bits, input logic [6:0] exp, input string tag);
    for (int i = 6; i >= 0; i--)
      step_b(2'b01, {1'b0, bits[i]}, 1'b0, {1'b0, exp[i]}, tag);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus_a.linea   = '0;
    bus_a.abilita = '0;
    bus_a.sovrapp = 1'b0;
    bus_a.azzera  = 1'b0;
    bus_b.linea   = '0;
    bus_b.abilita = '0;
    bus_b.sovrapp = 1'b1;
    bus_b.azzera  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_u_a", {28'd0, bus_a.u}, 32'd0);
    check("rst_any_a", {31'd0, bus_a.any_u}, 32'd0);
    check("rst_u_b", {30'd0, bus_b.u}, 32'd0);
`ifdef LINEA_RECOG_COUNT_EN
    check("rst_cnt_a", bus_a.conteggio, 32'd0);
`endif
    reset = 1'b0;

    // Basic detection of 10011 on channel 0, one-cycle pulse
    step_a(4'b0001, 4'b0000, 4'b0000, "t1_init");
    stream_a(5'b10011, 5'b00001, "t1");
`ifdef LINEA_RECOG_COUNT_EN
    check("t1_cnt", bus_a.conteggio, 32'h0000_0001);
`endif
    step_a(4'b0001, 4'b0000, 4'b0000, "t1_end");

    // Reset mid-pattern, then a full pattern gives exactly one match
    stream_a(5'b00100, 5'b00000, "t4_pre");
    reset = 1'b1;
    step_a(4'b0001, 4'b0001, 4'b0000, "t4_rst");
`ifdef LINEA_RECOG_COUNT_EN
    check("t4_rst_cnt", bus_a.conteggio, 32'd0);
`endif
    reset = 1'b0;
    step_a(4'b0001, 4'b0001, 4'b0000, "t4_init");
    stream_a(5'b10011, 5'b00001, "t4");
    step_a(4'b0001, 4'b0000, 4'b0000, "t4_end");
`ifdef LINEA_RECOG_COUNT_EN
    check("t4_cnt", bus_a.conteggio, 32'h0000_0001);
`endif

    // Channel 1 briefly disabled mid-pattern; channel 0 unaffected
    step_a(4'b0000, 4'b0000, 4'b0000, "t5_off");
    step_a(4'b0011, 4'b0000, 4'b0000, "t5_init");
    step_a(4'b0011, 4'b0011, 4'b0000, "t5_c1");
    step_a(4'b0011, 4'b0000, 4'b0000, "t5_c2");
    step_a(4'b0001, 4'b0000, 4'b0000, "t5_c3");
    step_a(4'b0011, 4'b0011, 4'b0000, "t5_c4");
    step_a(4'b0011, 4'b0011, 4'b0001, "t5_c5");
    step_a(4'b0011, 4'b0000, 4'b0000, "t5_c6");
    step_a(4'b0011, 4'b0000, 4'b0000, "t5_c7");
    step_a(4'b0011, 4'b0010, 4'b0000, "t5_c8");
    step_a(4'b0011, 4'b0010, 4'b0010, "t5_c9");
`ifdef LINEA_RECOG_COUNT_EN
    check("t5_cnt", bus_a.conteggio, 32'h0000_0102);
`endif

    // Pattern 10101: overlapping then non-overlapping
    step_b(2'b01, 2'b00, 1'b0, 2'b00, "t2_init");
    stream_b(7'b1010101, 7'b0000101, "t2_ov");
`ifdef LINEA_RECOG_COUNT_EN
    check("t2_ov_cnt", {30'd0, bus_b.conteggio[1:0]}, 32'd2);
`endif
    step_b(2'b00, 2'b00, 1'b0, 2'b00, "t2_off");
    bus_b.sovrapp = 1'b0;
    step_b(2'b01, 2'b00, 1'b0, 2'b00, "t2_init2");
    stream_b(7'b1010101, 7'b0000100, "t2_nov");
`ifdef LINEA_RECOG_COUNT_EN
    check("t2_nov_cnt", {30'd0, bus_b.conteggio[1:0]}, 32'd3);
`endif

    // Saturation at 3 after five matches, then clear coincident with a match
    step_b(2'b00, 2'b00, 1'b0, 2'b00, "t3_off");
    bus_b.sovrapp = 1'b1;
    step_b(2'b01, 2'b00, 1'b0, 2'b00, "t3_init");
    stream_b(7'b1010101, 7'b0000101, "t3_sat");
`ifdef LINEA_RECOG_COUNT_EN
    check("t3_sat_cnt", {30'd0, bus_b.conteggio[1:0]}, 32'd3);
`endif
    step_b(2'b01, 2'b00, 1'b0, 2'b00, "t3_b8");
    step_b(2'b01, 2'b01, 1'b1, 2'b01, "t3_clr_match");
`ifdef LINEA_RECOG_COUNT_EN
    check("t3_clr_match_cnt", {30'd0, bus_b.conteggio[1:0]}, 32'd1);
`endif
    step_b(2'b01, 2'b00, 1'b1, 2'b00, "t3_clr");
`ifdef LINEA_RECOG_COUNT_EN
    check("t3_clr_cnt", {30'd0, bus_b.conteggio[1:0]}, 32'd0);
    check("t3_ch1_cnt", {30'd0, bus_b.conteggio[3:2]}, 32'd0);
`endif
    bus_b.azzera = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
